tty_ctrl: RTL and testbench
===========================

Name: tty_ctrl

Overview:
- Parametrised successor to the single-register terminal bridge between the CPU bus, the PS/2 keyboard decoder and the VGA text engine.
- Adds:
  - a keyboard receive FIFO, so keystrokes are not lost between CPU polls;
  - a status register;
  - hardware cursor tracking that turns CPU character writes into video-memory address/data writes;
  - handling of the newline, carriage-return and backspace control codes.
- Sits on the CPU bus next to memory. Drives the VGA text RAM write port. Consumes the keyboard decoder's ascii byte and its one-cycle released pulse.

Parameters:
- DATA_W, 32, CPU bus width; at least 16.
- FIFO_DEPTH, 16, receive FIFO entries; power of two, at least 2.
- COLS, 80, text columns.
- ROWS, 30, text rows.
- VADDR_W, 12, video address width; 2^VADDR_W must be at least COLS*ROWS.

Ports:
- clk_50mhz  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- bus_addr  in  1  register select: 0 = DATA, 1 = STATUS.
- bus_wdata  in  DATA_W  CPU write data; bits [7:0] used.
- bus_rdata  out  DATA_W  CPU read data; zero when read=0.
- read  in  1  CPU read strobe; one cycle per access.
- write  in  1  CPU write strobe; one cycle per access.
- kb_ascii  in  8  decoded key from the keyboard decoder.
- kb_released  in  1  one-cycle pulse; kb_ascii is valid in the same cycle.
- vm_write  out  1  video RAM write enable; one-cycle pulse.
- vm_addr  out  VADDR_W  video RAM address, equal to row*COLS+col.
- vm_data  out  8  character to video RAM.
- keypress  out  1  FIFO not empty; level signal, usable as an interrupt.

Behaviour:
- Reset: FIFO empty, overflow flag=0, col=0, row=0. vm_write=0, vm_addr=0, vm_data=0, keypress=0, bus_rdata=0.
- Receive FIFO push:
  - kb_released=1 pushes kb_ascii.
  - If the FIFO is full and no pop occurs in the same cycle, the byte is dropped and the sticky overflow flag is set.
- Receive FIFO pop:
  - read=1 with bus_addr=0 is a pop.
  - bus_rdata = {0, head byte} combinationally during the strobe; the pop takes effect at the clock edge.
  - Read of an empty FIFO returns 0 and does not pop.
- Push and pop in the same cycle: both are performed. This holds when full (the count stays at FIFO_DEPTH, no overflow). When empty, the popped data is 0 and the pushed byte is stored.
- Pointers wrap modulo FIFO_DEPTH. The count is held in clog2(FIFO_DEPTH)+1 bits.
- STATUS read (bus_addr=1), bus_rdata fields:
  - bit0 = not empty;
  - bit1 = full;
  - bit2 = overflow;
  - bits[15:8] = count, zero-extended.
  - A STATUS read clears overflow at the edge. If an overflow occurs in the same cycle, the flag stays set (set wins).
- Writes: STATUS writes are ignored. A DATA write feeds the cursor FSM with bus_wdata[7:0].
- Cursor FSM, one character per cycle, vm_write registered so latency is 1 cycle after the write strobe:
  - 0x0A or 0x0D: col=0, row=row+1 (row wraps ROWS-1 -> 0). No vm_write.
  - 0x08 with col>0: col=col-1; vm_write with vm_data=0x20 at the new position.
  - 0x08 with col=0: no action, no vm_write.
  - Any other byte: vm_write with vm_data=byte at the current position; then col=col+1.
  - Column wrap: col=COLS-1 -> col=0, row=row+1. Row wrap: row=ROWS-1 -> 0. There is no scrolling.
- vm_addr and vm_data hold their last values when vm_write=0.
- Simultaneous kb_released and DATA write: both are handled in the same cycle (FIFO push plus cursor action).
- Reset asserted mid-operation wins over every pending action in that cycle.

Optional Feature:
- Macro TTY_ECHO_EN.
- When defined:
  - Each kb_released byte is also sent to the cursor FSM as a local echo, in addition to the FIFO push.
  - A CPU DATA write in the same cycle takes priority. The echo byte is held in a one-entry pending register and emitted in the next cycle that has no CPU write.
  - A second keypress while an echo is pending overwrites the pending byte. The FIFO still receives both bytes.
- When undefined: keyboard input reaches only the FIFO. No pending register is built.

Test Plan:
- Reset, then write 0x41 to DATA -> one cycle later vm_write=1, vm_addr=0, vm_data=0x41; col becomes 1.
- 80 writes of 0x42, then 0x43 -> the last write goes to vm_addr=80; row=1, col=1. Write 0x0A at row 29 -> row=0.
- Write 0x41, 0x08 -> second vm_write has vm_addr=0, vm_data=0x20. Another 0x08 at col=0 -> no vm_write.
- 17 kb_released pulses (0x61..0x71) with FIFO_DEPTH=16 -> STATUS = 0x1007 (count 16, full, overflow, valid). 16 DATA reads return 0x61..0x70. Next STATUS read returns 0x0000.
- With the FIFO full, kb_released and a DATA read in the same cycle -> read returns the head byte, count stays 16, overflow stays 0.
- With TTY_ECHO_EN defined: kb_released(0x5A) in the same cycle as CPU write 0x31 -> vm_write 0x31 at addr 0, then 0x5A at addr 1 in the following cycle.

Source files
------------

// File: rtl/tty_ctrl.sv
// tty_ctrl: CPU-bus terminal bridge with keyboard receive FIFO, status register and cursor-tracked video RAM writes.
// Optional macro TTY_ECHO_EN adds local echo of keystrokes to the screen through a one-entry pending register.
module tty_ctrl #(
  parameter int DATA_W = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int COLS = 80,
  parameter int ROWS = 30,
  parameter int VADDR_W = 12
) (
  input  logic               clk_50mhz,
  input  logic               rst,
  input  logic               bus_addr,
  input  logic [DATA_W-1:0]  bus_wdata,
  output logic [DATA_W-1:0]  bus_rdata,
  input  logic               read,
  input  logic               write,
  input  logic [7:0]         kb_ascii,
  input  logic               kb_released,
  output logic               vm_write,
  output logic [VADDR_W-1:0] vm_addr,
  output logic [7:0]         vm_data,
  output logic               keypress
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);

  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic ovf, empty, full, pop, push_ok, ovf_set;
  logic [DATA_W-1:0] status;
  logic unused_wdata;

  assign unused_wdata = ^bus_wdata[DATA_W-1:8];
  assign empty = count == '0;
  assign full = count == (AW+1)'(FIFO_DEPTH);
  assign pop = read && !bus_addr && !empty;
  assign push_ok = kb_released && (!full || pop);
  assign ovf_set = kb_released && full && !pop;
  assign keypress = !empty;

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      ovf <= 1'b0;
    end else begin
      wr_ptr <= push_ok ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop);
      ovf <= ovf_set || (ovf && !(read && bus_addr));
    end
  end

  always_ff @(posedge clk_50mhz)
    if (push_ok) mem[wr_ptr] <= kb_ascii;

  always_comb begin
    status = '0;
    status[15:8] = 8'(count);
    status[2:0] = {ovf, full, !empty};
    bus_rdata = !read ? '0 : bus_addr ? status : {{(DATA_W-8){1'b0}}, empty ? 8'h00 : mem[rd_ptr]};
  end

  logic cpu_wr, ch_v;
  logic [7:0] ch;
  assign cpu_wr = write && !bus_addr;

`ifdef TTY_ECHO_EN
  // A CPU write wins the cursor; a colliding keystroke waits one slot, newer keys replace it.
  logic pend_v;
  logic [7:0] pend;
  assign ch_v = cpu_wr || kb_released || pend_v;
  assign ch = cpu_wr ? bus_wdata[7:0] : kb_released ? kb_ascii : pend;

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      pend_v <= 1'b0;
      pend <= 8'h00;
    end else begin
      pend_v <= cpu_wr ? (kb_released || pend_v) : 1'b0;
      pend <= (cpu_wr && kb_released) ? kb_ascii : pend;
    end
  end
`else
  assign ch_v = cpu_wr;
  assign ch = bus_wdata[7:0];
`endif

  logic [CW-1:0] col, col_n;
  logic [RW-1:0] row, row_n, row_inc;
  logic is_nl, is_bs, wr_n;
  logic [VADDR_W-1:0] addr_n;
  logic [7:0] data_n;

  assign is_nl = ch == 8'h0A || ch == 8'h0D;
  assign is_bs = ch == 8'h08;
  assign row_inc = row == ROW_MAX ? '0 : row + 1'b1;

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      col <= '0;
      row <= '0;
      vm_write <= 1'b0;
      vm_addr <= '0;
      vm_data <= 8'h00;
    end else begin
      col <= col_n;
      row <= row_n;
      vm_write <= wr_n;
      vm_addr <= wr_n ? addr_n : vm_addr;
      vm_data <= wr_n ? data_n : vm_data;
    end
  end

  always_comb begin
    col_n = col;
    row_n = row;
    if (ch_v && is_nl) begin
      col_n = '0;
      row_n = row_inc;
    end else if (ch_v && is_bs) begin
      col_n = col == '0 ? col : col - 1'b1;
    end else if (ch_v) begin
      col_n = col == COL_MAX ? '0 : col + 1'b1;
      row_n = col == COL_MAX ? row_inc : row;
    end
  end

  // Backspace blanks the cell it moves onto, so its address uses the decremented column.
  always_comb begin
    wr_n = ch_v && !is_nl && !(is_bs && col == '0);
    data_n = is_bs ? 8'h20 : ch;
    addr_n = VADDR_W'(row) * VADDR_W'(COLS) + VADDR_W'(is_bs ? col - 1'b1 : col);
  end
endmodule

// File: tb/tb_tty_ctrl.sv
// tb_tty_ctrl: directed and randomized bench for tty_ctrl against a queue/linear-position reference model.
module tb_tty_ctrl;
  localparam int D = 16, COLS = 80, ROWS = 30;

  logic clk_50mhz = 1'b0, rst = 1'b1, bus_addr = 1'b0, read = 1'b0, write = 1'b0, kb_released = 1'b0;
  logic [31:0] bus_wdata = '0, bus_rdata;
  logic [7:0] kb_ascii = '0, vm_data;
  logic [11:0] vm_addr;
  logic vm_write, keypress;

  int n_checks = 0, n_fail = 0;
  byte unsigned q[$];
  bit m_ovf, exp_w, m_pv;
  int mpos;
  logic [11:0] exp_a;
  logic [7:0] exp_d, m_pend;

  tty_ctrl dut (.clk_50mhz(clk_50mhz), .rst(rst), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .read(read), .write(write), .kb_ascii(kb_ascii), .kb_released(kb_released),
    .vm_write(vm_write), .vm_addr(vm_addr), .vm_data(vm_data), .keypress(keypress));

  always #5 clk_50mhz = ~clk_50mhz;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Screen is a linear position; wraps fall out of modulo arithmetic.
  task automatic model_char(input logic [7:0] c);
    if (c == 8'h0A || c == 8'h0D) mpos = ((mpos / COLS + 1) % ROWS) * COLS;
    else if (c == 8'h08) begin
      if (mpos % COLS != 0) begin
        mpos--;
        exp_w = 1; exp_a = 12'(mpos); exp_d = 8'h20;
      end
    end else begin
      exp_w = 1; exp_a = 12'(mpos); exp_d = c;
      mpos = (mpos + 1) % (COLS * ROWS);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 0; exp_w = 0; m_pv = 0; mpos = 0; exp_a = '0; exp_d = '0; m_pend = '0;
  endtask

  task automatic step(input logic r, input logic w, input logic a, input logic [7:0] wd,
                      input logic k, input logic [7:0] ka);
    logic [31:0] er;
    bit pop, oset;
    read = r; write = w; bus_addr = a; bus_wdata = {24'($urandom), wd}; kb_released = k; kb_ascii = ka;
    er = '0;
    if (r && a) er = {16'h0, 8'(q.size()), 5'b0, m_ovf, q.size() == D, q.size() != 0};
    else if (r && q.size() != 0) er = {24'h0, q[0]};
    #1 check("bus_rdata", bus_rdata, er);
    pop = r && !a && q.size() != 0;
    if (pop) void'(q.pop_front());
    oset = k && q.size() == D;
    if (k && !oset) q.push_back(ka);
    m_ovf = oset ? 1'b1 : (r && a) ? 1'b0 : m_ovf;
    exp_w = 0;
`ifdef TTY_ECHO_EN
    if (w && !a) begin
      model_char(wd);
      if (k) begin m_pv = 1; m_pend = ka; end
    end else if (k) begin
      model_char(ka); m_pv = 0;
    end else if (m_pv) begin
      model_char(m_pend); m_pv = 0;
    end
`else
    if (w && !a) model_char(wd);
`endif
    @(posedge clk_50mhz); #1;
    check("vm_write", vm_write, exp_w);
    check("vm_addr", vm_addr, exp_a);
    check("vm_data", vm_data, exp_d);
    check("keypress", keypress, q.size() != 0);
  endtask

  task automatic do_reset();
    rst = 1; read = 1; write = 1; bus_addr = 0; bus_wdata = 32'h41; kb_released = 1; kb_ascii = 8'h55;
    @(posedge clk_50mhz); #1;
    rst = 0; read = 0; write = 0; kb_released = 0;
    model_reset();
    #1;
    check("rst_vm_write", vm_write, 0);
    check("rst_vm_addr", vm_addr, 0);
    check("rst_vm_data", vm_data, 0);
    check("rst_keypress", keypress, 0);
    check("rst_rdata", bus_rdata, 0);
  endtask

  task automatic wr(input logic [7:0] c);
    step(0, 1, 0, c, 0, 8'h00);
  endtask

  task automatic kb(input logic [7:0] c);
    step(0, 0, 0, 8'h00, 1, c);
  endtask

  initial begin
    logic [7:0] c;
    model_reset();
    @(posedge clk_50mhz); @(posedge clk_50mhz); #1;
    do_reset();
    wr(8'h41);
    check("first_addr", vm_addr, 0);
    check("first_data", vm_data, 8'h41);
    do_reset();
    for (int i = 0; i < 80; i++) wr(8'h42);
    wr(8'h43);
    check("colwrap_addr", vm_addr, 80);
    for (int i = 0; i < 28; i++) wr(8'h0A);
    wr(8'h0A);
    wr(8'h58);
    check("rowwrap_addr", vm_addr, 0);
    do_reset();
    wr(8'h41);
    wr(8'h08);
    check("bs_addr", vm_addr, 0);
    check("bs_data", vm_data, 8'h20);
    wr(8'h08);
    check("bs_col0", vm_write, 0);
    for (int i = 0; i < 17; i++) kb(8'(8'h61 + i));
    step(1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 16; i++) kb(8'(8'h70 + i));
    step(1, 0, 0, 0, 1, 8'h7A);
    step(1, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 1, 8'h20);
    do_reset();
`ifdef TTY_ECHO_EN
    step(0, 1, 0, 8'h31, 1, 8'h5A);
    step(0, 0, 0, 0, 0, 0);
    check("echo_addr", vm_addr, 1);
    check("echo_data", vm_data, 8'h5A);
`endif
    for (int i = 0; i < 4000; i++) begin
      int ph;
      ph = (i / 500) % 2;
      if ($urandom_range(0, 599) == 0) do_reset();
      case ($urandom_range(0, 9))
        0: c = 8'h0A;
        1: c = 8'h0D;
        2, 3: c = 8'h08;
        default: c = 8'($urandom_range(32, 126));
      endcase
      step($urandom_range(0, 9) < (ph ? 5 : 1), $urandom_range(0, 9) < 4, 1'($urandom),
           c, $urandom_range(0, 9) < (ph ? 3 : 5), 8'($urandom));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
